// File: rtl/game_state_controller.sv
// Frog game sequencer: samples per-frame collision flags and runs lives, level
// progression, freeze timing, respawn and game-over around the collision datapath.
module game_state_controller #(
  parameter int START_LIVES   = 3,
  parameter int MAX_LEVEL     = 9,
  parameter int FREEZE_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic       death_collision,
  input  logic       win_collision,
  output logic [3:0] current_level,
  output logic [1:0] lives,
  output logic [2:0] state,
  output logic       movement_enable,
  output logic       frog_reset,
  output logic       level_up,
  output logic       game_over
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PLAY      = 3'd1,
    S_DEATH     = 3'd2,
    S_LEVEL_UP  = 3'd3,
    S_GAME_OVER = 3'd4
  } state_t;

  localparam logic [1:0] START_LIVES_V = 2'(START_LIVES);
  localparam logic [3:0] MAX_LEVEL_V   = 4'(MAX_LEVEL);
  localparam logic [7:0] FREEZE_V      = 8'(FREEZE_FRAMES);

  state_t     state_q, state_d;
  logic [3:0] level_q, level_d;
  logic [1:0] lives_q, lives_d;
  logic [7:0] freeze_q, freeze_d;
  logic       start_prev_q;
  logic       start_rise;
  logic       frog_reset_q, frog_reset_d;
  logic       level_up_q, level_up_d;
  logic       move_en_q, game_over_q;

  assign start_rise = start_btn & ~start_prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      level_q      <= 4'd0;
      lives_q      <= 2'd0;
      freeze_q     <= 8'd0;
      start_prev_q <= 1'b0;
      frog_reset_q <= 1'b0;
      level_up_q   <= 1'b0;
      move_en_q    <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      lives_q      <= lives_d;
      freeze_q     <= freeze_d;
      start_prev_q <= start_btn;
      frog_reset_q <= frog_reset_d;
      level_up_q   <= level_up_d;
      move_en_q    <= (state_d == S_PLAY);
      game_over_q  <= (state_d == S_GAME_OVER);
    end
  end

  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    lives_d      = lives_q;
    freeze_d     = freeze_q;
    frog_reset_d = 1'b0;
    level_up_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_rise) begin
          state_d      = S_PLAY;
          level_d      = 4'd1;
          lives_d      = START_LIVES_V;
          frog_reset_d = 1'b1;
        end
      end

      // Death outranks a simultaneous win; the last life goes straight to game over.
      S_PLAY: begin
        if (frame_tick) begin
          if (death_collision) begin
            if (lives_q > 2'd1) begin
              lives_d  = lives_q - 2'd1;
              state_d  = S_DEATH;
              freeze_d = FREEZE_V;
            end else begin
              lives_d = 2'd0;
              state_d = S_GAME_OVER;
            end
          end else if (win_collision) begin
            state_d    = S_LEVEL_UP;
            freeze_d   = FREEZE_V;
            level_up_d = 1'b1;
            level_d    = (level_q >= MAX_LEVEL_V) ? MAX_LEVEL_V : level_q + 4'd1;
          end
        end
      end

      S_DEATH, S_LEVEL_UP: begin
        if (frame_tick) begin
          if (freeze_q <= 8'd1) begin
            freeze_d     = 8'd0;
            state_d      = S_PLAY;
            frog_reset_d = 1'b1;
          end else begin
            freeze_d = freeze_q - 8'd1;
          end
        end
      end

      S_GAME_OVER: begin
        if (start_rise) begin
          state_d = S_IDLE;
          level_d = 4'd0;
        end
      end

      default: begin
        state_d  = S_IDLE;
        level_d  = 4'd0;
        lives_d  = 2'd0;
        freeze_d = 8'd0;
      end
    endcase
  end

  assign state           = state_q;
  assign current_level   = level_q;
  assign lives           = lives_q;
  assign movement_enable = move_en_q;
  assign frog_reset      = frog_reset_q;
  assign level_up        = level_up_q;
  assign game_over       = game_over_q;

endmodule
